// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and data memory.
// Stores are queued in FIFO order and drained one per memory ack.
// Loads are forwarded from the youngest matching buffered store.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_st_valid,
  input  logic [AW-1:0]            i_st_addr,
  input  logic [31:0]              i_st_data,
  output logic                     o_st_ready,
  input  logic                     i_ld_valid,
  input  logic [AW-1:0]            i_ld_addr,
  output logic                     o_ld_hit,
  output logic [31:0]              o_ld_data,
  output logic                     o_mem_wr_en,
  output logic [AW-1:0]            o_mem_addr,
  output logic [31:0]              o_mem_wdata,
  input  logic                     i_mem_ack,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = AW - 2;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Entry storage holds the word address only; byte offset is dropped.
  logic [WW-1:0]    ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [DEPTH-1:0] ent_valid;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  state_t        state;

  logic          push;
  logic          pop;
  logic [PW-1:0] ld_idx;

  // Handshake qualifiers; ready depends only on current occupancy, so a
  // full buffer rejects a store even when a drain completes this cycle.
  assign o_st_ready = (count < FULL_CNT);
  assign push       = i_st_valid && o_st_ready;
  assign pop        = (state == BUSY) && i_mem_ack;

  // Occupancy after this edge.
  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Payload write at the tail.
  // NOTE: the payload arrays are deliberately not reset; ent_valid alone
  // qualifies them, which keeps them plain RAM without a reset tree.
  always_ff @(posedge i_clk) begin
    if (push) begin
      ent_addr[tail] <= i_st_addr[AW-1:2];
      ent_data[tail] <= i_st_data;
    end
  end

  // Pointers, valid bits, occupancy and drain FSM.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ent_valid <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      state     <= IDLE;
    end else begin
      if (push) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PW'(1);
      end
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PW'(1);
      end
      count <= count_next;
      unique case (state)
        IDLE: if (count_next != '0) state <= BUSY;
        BUSY: if (pop && (count_next == '0)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Drain request presents the head entry; it only moves on an ack.
  assign o_mem_wr_en = (state == BUSY);
  assign o_mem_addr  = (state == BUSY) ? {ent_addr[head], 2'b00} : '0;
  assign o_mem_wdata = (state == BUSY) ? ent_data[head] : '0;
  assign o_empty     = (count == '0);
  assign o_count     = count;

  // Load forwarding: walk from oldest to youngest so the youngest match
  // overrides; only pre-edge valid entries (including an acked head) count.
  // NOTE: every output of this block gets a default first so no latch forms.
  always_comb begin
    o_ld_hit  = 1'b0;
    o_ld_data = '0;
    ld_idx    = head;
    if (i_ld_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        ld_idx = head + PW'(i);
        if (ent_valid[ld_idx] && (ent_addr[ld_idx] == i_ld_addr[AW-1:2])) begin
          o_ld_hit  = 1'b1;
          o_ld_data = ent_data[ld_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenario tasks plus a queue scoreboard
// that models buffer contents, drain order and load forwarding each cycle.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        empty;
  logic [2:0]  count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int drained   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t sb[$];

  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_st_valid  (st_valid),
    .i_st_addr   (st_addr),
    .i_st_data   (st_data),
    .o_st_ready  (st_ready),
    .i_ld_valid  (ld_valid),
    .i_ld_addr   (ld_addr),
    .o_ld_hit    (ld_hit),
    .o_ld_data   (ld_data),
    .o_mem_wr_en (mem_wr_en),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_ack   (mem_ack),
    .o_empty     (empty),
    .o_count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: at each falling edge compare outputs against the queue,
  // then apply the push/pop the coming rising edge will perform.
  always @(negedge clk) begin
    int          n;
    logic        e_hit;
    logic [31:0] e_data;
    logic        do_pop;
    logic        do_push;
    if (!rst_n) begin
      sb.delete();
    end else begin
      n = sb.size();
      total_cnt++;
      if (count !== 3'(n)) $display("FAIL sb_count: got %0d want %0d", count, n);
      else pass_cnt++;
      total_cnt++;
      if (st_ready !== (n < DEPTH)) $display("FAIL sb_ready: got %0b want %0b", st_ready, (n < DEPTH));
      else pass_cnt++;
      total_cnt++;
      if (empty !== (n == 0)) $display("FAIL sb_empty: got %0b want %0b", empty, (n == 0));
      else pass_cnt++;
      total_cnt++;
      if (mem_wr_en !== (n != 0)) $display("FAIL sb_wr_en: got %0b want %0b", mem_wr_en, (n != 0));
      else pass_cnt++;
      if (n != 0) begin
        total_cnt++;
        if (mem_addr !== sb[0].addr || mem_wdata !== sb[0].data)
          $display("FAIL sb_drain: got %h/%h want %h/%h", mem_addr, mem_wdata, sb[0].addr, sb[0].data);
        else pass_cnt++;
      end
      e_hit  = 1'b0;
      e_data = 32'h0;
      if (ld_valid) begin
        for (int i = 0; i < n; i++) begin
          if (sb[i].addr[31:2] == ld_addr[31:2]) begin
            e_hit  = 1'b1;
            e_data = sb[i].data;
          end
        end
      end
      total_cnt++;
      if (ld_hit !== e_hit || ld_data !== e_data)
        $display("FAIL sb_load: addr %h got %0b/%h want %0b/%h", ld_addr, ld_hit, ld_data, e_hit, e_data);
      else pass_cnt++;
      do_pop  = mem_ack && (n != 0);
      do_push = st_valid && (n < DEPTH);
      if (do_pop) begin
        void'(sb.pop_front());
        drained++;
      end
      if (do_push) sb.push_back('{addr: {st_addr[31:2], 2'b00}, data: st_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_all();
    mem_ack = 1'b1;
    for (int i = 0; i < 50 && !empty; i++) tick();
    mem_ack = 1'b0;
    total_cnt++;
    if (empty !== 1'b1) $display("FAIL drain_timeout: empty %0b want 1", empty);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0; mem_ack = 1'b0;
    tick(); tick();
    total_cnt++;
    if (mem_wr_en !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0)
      $display("FAIL reset_drain: got %0b %h %h want 0 0 0", mem_wr_en, mem_addr, mem_wdata);
    else pass_cnt++;
    total_cnt++;
    if (empty !== 1'b1 || st_ready !== 1'b1 || count !== 3'd0)
      $display("FAIL reset_status: got empty %0b ready %0b count %0d want 1 1 0", empty, st_ready, count);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_drain();
    st_valid = 1'b1; st_addr = 32'h100; st_data = 32'hAAAA0001;
    tick();
    st_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (mem_wr_en !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hAAAA0001)
        $display("FAIL single_hold%0d: got %0b %h %h want 1 100 aaaa0001", i, mem_wr_en, mem_addr, mem_wdata);
      else pass_cnt++;
      tick();
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    total_cnt++;
    if (empty !== 1'b1 || mem_wr_en !== 1'b0)
      $display("FAIL single_done: got empty %0b wr_en %0b want 1 0", empty, mem_wr_en);
    else pass_cnt++;
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      st_valid = 1'b1; st_addr = 32'h400 + 32'(i * 4); st_data = 32'hF000 + 32'(i);
      tick();
    end
    st_valid = 1'b0;
    total_cnt++;
    if (st_ready !== 1'b0 || count !== 3'd4)
      $display("FAIL full_state: got ready %0b count %0d want 0 4", st_ready, count);
    else pass_cnt++;
    st_valid = 1'b1; st_addr = 32'h500; st_data = 32'h5555;
    tick();
    total_cnt++;
    if (count !== 3'd4) $display("FAIL full_reject: got count %0d want 4", count);
    else pass_cnt++;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; st_valid = 1'b0;
    total_cnt++;
    if (count !== 3'd3 || st_ready !== 1'b1)
      $display("FAIL full_ack_push: got count %0d ready %0b want 3 1", count, st_ready);
    else pass_cnt++;
    drain_all();
  endtask

  task automatic test_forwarding();
    st_valid = 1'b1; st_addr = 32'h200; st_data = 32'h11;
    tick();
    st_data = 32'h22;
    tick();
    st_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h203;
    #1;
    total_cnt++;
    if (ld_hit !== 1'b1 || ld_data !== 32'h22)
      $display("FAIL fwd_youngest: got %0b/%h want 1/00000022", ld_hit, ld_data);
    else pass_cnt++;
    ld_addr = 32'h204;
    #1;
    total_cnt++;
    if (ld_hit !== 1'b0 || ld_data !== 32'h0)
      $display("FAIL fwd_miss: got %0b/%h want 0/00000000", ld_hit, ld_data);
    else pass_cnt++;
    ld_valid = 1'b0; ld_addr = 32'h200;
    #1;
    total_cnt++;
    if (ld_hit !== 1'b0 || ld_data !== 32'h0)
      $display("FAIL fwd_novalid: got %0b/%h want 0/00000000", ld_hit, ld_data);
    else pass_cnt++;
    drain_all();
  endtask

  task automatic test_same_cycle();
    st_valid = 1'b1; st_addr = 32'h300; st_data = 32'h33;
    ld_valid = 1'b1; ld_addr = 32'h300;
    #1;
    total_cnt++;
    if (ld_hit !== 1'b0) $display("FAIL same_cycle_hidden: got hit %0b want 0", ld_hit);
    else pass_cnt++;
    tick();
    st_valid = 1'b0;
    #1;
    total_cnt++;
    if (ld_hit !== 1'b1 || ld_data !== 32'h33)
      $display("FAIL same_cycle_next: got %0b/%h want 1/00000033", ld_hit, ld_data);
    else pass_cnt++;
    ld_valid = 1'b0;
    drain_all();
  endtask

  task automatic test_random();
    int pushed = 0;
    int start  = drained;
    for (int cyc = 0; cyc < 20000 && pushed < 1000; cyc++) begin
      st_valid = (pushed < 1000) && ($urandom_range(3) != 0);
      st_addr  = 32'h1000 + 32'($urandom_range(7) * 4) + 32'($urandom_range(3));
      st_data  = $urandom;
      mem_ack  = ($urandom_range(1) == 1);
      ld_valid = ($urandom_range(1) == 1);
      ld_addr  = 32'h1000 + 32'($urandom_range(7) * 4);
      if (st_valid && sb.size() < DEPTH) pushed++;
      tick();
    end
    st_valid = 1'b0; ld_valid = 1'b0;
    drain_all();
    total_cnt++;
    if (pushed != 1000 || (drained - start) != 1000)
      $display("FAIL random_stream: pushed %0d drained %0d want 1000 1000", pushed, drained - start);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1; st_addr = 32'h700 + 32'(i * 4); st_data = 32'h7000 + 32'(i);
      tick();
    end
    st_valid = 1'b0;
    total_cnt++;
    if (count !== 3'd3 || mem_wr_en !== 1'b1)
      $display("FAIL areset_pre: got count %0d wr_en %0b want 3 1", count, mem_wr_en);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (mem_wr_en !== 1'b0 || count !== 3'd0 || empty !== 1'b1)
      $display("FAIL areset_now: got wr_en %0b count %0d empty %0b want 0 0 1", mem_wr_en, count, empty);
    else pass_cnt++;
    tick(); tick();
    rst_n = 1'b1;
    mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if (mem_wr_en !== 1'b0) $display("FAIL areset_quiet%0d: got wr_en %0b want 0", i, mem_wr_en);
      else pass_cnt++;
    end
    mem_ack = 1'b0;
    st_valid = 1'b1; st_addr = 32'h804; st_data = 32'h8888;
    tick();
    st_valid = 1'b0;
    total_cnt++;
    if (mem_wr_en !== 1'b1 || mem_addr !== 32'h804 || mem_wdata !== 32'h8888)
      $display("FAIL areset_resume: got %0b %h %h want 1 804 8888", mem_wr_en, mem_addr, mem_wdata);
    else pass_cnt++;
    drain_all();
  endtask

  initial begin
    test_reset();
    test_single_drain();
    test_full();
    test_forwarding();
    test_same_cycle();
    test_random();
    test_async_reset();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
